// File: rtl/packet_generator_ctrl_if.sv
// Purpose: handshake and framing bundle between the DLLP/TLP requesters,
//          the packet generator controller and the shift-out stage.
// Signals:
//   i_tx_en, i_dllp_req, i_tlp_req      requester/link side -> controller
//   o_dllp_ack, o_tlp_ack               controller -> requesters (1-cycle pulses)
//   o_load_frame, o_sel_dllp            controller -> shift-out stage
//   o_byte_src, o_pkt_dllp, o_busy      controller -> byte mux / status
// Modports: master = requester/link side, slave = controller.
interface packet_generator_ctrl_if;
  logic       i_tx_en;
  logic       i_dllp_req;
  logic       i_tlp_req;
  logic       o_dllp_ack;
  logic       o_tlp_ack;
  logic       o_load_frame;
  logic       o_sel_dllp;
  logic [1:0] o_byte_src;
  logic       o_pkt_dllp;
  logic       o_busy;

  modport master (
    output i_tx_en, i_dllp_req, i_tlp_req,
    input  o_dllp_ack, o_tlp_ack, o_load_frame, o_sel_dllp,
           o_byte_src, o_pkt_dllp, o_busy
  );

  modport slave (
    input  i_tx_en, i_dllp_req, i_tlp_req,
    output o_dllp_ack, o_tlp_ack, o_load_frame, o_sel_dllp,
           o_byte_src, o_pkt_dllp, o_busy
  );
endinterface

// File: rtl/packet_generator_ctrl.sv
// Purpose: transmit framing controller upstream of the byte shift-out
//          register. Arbitrates DLLP (strict priority) over TLP, pulses
//          load/select into the shift-out stage and tags each byte slot as
//          IDLE, SOP, DATA or EOP. A packet is SOP, N data bytes, EOP.
// Ports:
//   i_clk    clock, all logic on posedge
//   i_rst_n  synchronous reset, active low
//   bus      packet_generator_ctrl_if.slave (requests in, acks/framing out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no packet; waiting for i_tx_en and a pending request
// SOP   | start symbol slot; frame loaded into shift-out, requester acked
// DATA  | one data byte per cycle, counter runs N-1 down to 0
// EOP   | end symbol slot; may re-arbitrate straight into SOP
module packet_generator_ctrl #(
  parameter int DLLP_FRAME_WIDTH = 16,
  parameter int TLP_FRAME_WIDTH  = 64
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  packet_generator_ctrl_if.slave bus
);

  function automatic int fun_sizeof_byte(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic int fun_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DLLP_BYTES = fun_sizeof_byte(DLLP_FRAME_WIDTH);
  localparam int TLP_BYTES  = fun_sizeof_byte(TLP_FRAME_WIDTH);
  localparam int CNT_W      = $clog2(fun_max(DLLP_BYTES, TLP_BYTES)) + 1;

  localparam logic [CNT_W-1:0] DLLP_LAST = CNT_W'(DLLP_BYTES - 1);
  localparam logic [CNT_W-1:0] TLP_LAST  = CNT_W'(TLP_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Encoding doubles as the byte-slot tag driven on o_byte_src.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SOP  = 2'b01,
    S_DATA = 2'b10,
    S_EOP  = 2'b11
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             pkt_dllp_q, pkt_dllp_nxt;
  logic             start_pkt;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      pkt_dllp_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      pkt_dllp_q <= pkt_dllp_nxt;
    end
  end

  assign start_pkt = bus.i_tx_en & (bus.i_dllp_req | bus.i_tlp_req);

  // Next-state logic
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = CNT_ZERO;
    pkt_dllp_nxt = pkt_dllp_q;
    unique case (state_q)
      S_IDLE, S_EOP: begin
        // EOP re-arbitrates exactly like IDLE so back-to-back packets
        // need no idle slot between them.
        if (start_pkt) begin
          state_nxt    = S_SOP;
          pkt_dllp_nxt = bus.i_dllp_req;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SOP: begin
        state_nxt = S_DATA;
        cnt_nxt   = pkt_dllp_q ? DLLP_LAST : TLP_LAST;
      end
      S_DATA: begin
        if (cnt_q == CNT_ZERO) begin
          state_nxt = S_EOP;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.o_load_frame = 1'b0;
    bus.o_sel_dllp   = 1'b0;
    bus.o_dllp_ack   = 1'b0;
    bus.o_tlp_ack    = 1'b0;
    if (state_q == S_SOP) begin
      // The shift-out stage captures the frame in this cycle, so the ack
      // releases the requester at the same edge.
      bus.o_load_frame = 1'b1;
      bus.o_sel_dllp   = pkt_dllp_q;
      bus.o_dllp_ack   = pkt_dllp_q;
      bus.o_tlp_ack    = ~pkt_dllp_q;
    end
  end

  assign bus.o_byte_src = state_q;
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_pkt_dllp = pkt_dllp_q;

endmodule
